// File: rtl/cordic_acc_sequencer.sv
// Batch sequencer for the cosine CORDIC + FP accumulator datapath: streams N operands
// in, tags them through the inner-function latency, and captures the accumulated sum.
module cordic_acc_sequencer #(
    parameter int INNER_LAT = 13,
    parameter int ACC_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dp_clk_en,
    output logic [31:0]      dp_data,
    output logic             acc_en,
    output logic             acc_restart,
    input  logic [31:0]      acc_result,
    output logic             busy,
    output logic [31:0]      result,
    output logic             done
);
    localparam int DRAIN_CYC = INNER_LAT + ACC_LAT;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     remaining;
    logic [DW-1:0]        drain_cnt;
    logic                 first_flag;
    logic [INNER_LAT-1:0] tag_valid, tag_first;
    logic                 accept, last_accept, abort_act;

    assign in_ready    = (state == RUN) && clk_en;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (remaining == CNT_W'(1));
    assign abort_act   = abort && ((state == RUN) || (state == DRAIN));
    assign dp_clk_en   = clk_en;
    assign dp_data     = accept ? in_data : 32'h0;
    assign acc_en      = tag_valid[INNER_LAT-1];
    assign acc_restart = tag_first[INNER_LAT-1];
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       state <= IDLE;
        else if (clk_en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count == '0) ? FIN : RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (abort) state_nxt = IDLE;
                     else if (drain_cnt == '0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tags shift every enabled edge regardless of state so idle cycles flush as bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining  <= '0;
            drain_cnt  <= '0;
            first_flag <= 1'b0;
            tag_valid  <= '0;
            tag_first  <= '0;
            result     <= '0;
            done       <= 1'b0;
        end else if (clk_en) begin
            done      <= (state_nxt == FIN);
            tag_valid <= {tag_valid[INNER_LAT-2:0], accept};
            tag_first <= {tag_first[INNER_LAT-2:0], accept && first_flag};
            if (abort_act) begin
                tag_valid  <= '0;
                tag_first  <= '0;
                remaining  <= '0;
                drain_cnt  <= '0;
                first_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        remaining  <= count;
                        first_flag <= (count != '0);
                        if (count == '0) result <= '0;
                    end
                    RUN: if (accept) begin
                        remaining  <= remaining - CNT_W'(1);
                        first_flag <= 1'b0;
                        if (last_accept) drain_cnt <= DW'(DRAIN_CYC);
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) result <= acc_result;
                        else                 drain_cnt <= drain_cnt - DW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
